// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter sharing one synchronous RAM port.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   m0_*/m1_* req/wr/lock/addr/din  requester access requests
//   m0_*/m1_* gnt               same-cycle accept
//   m0_*/m1_* rvalid/rdata      read return, one cycle after a read grant
//   ram_wr/ram_addr/ram_din     RAM port drive (addr/din hold when idle)
//   ram_dout                    RAM registered read data
module ram_port_arbiter #(
    parameter int unsigned DATA = 16,
    parameter int unsigned ADDR = 13
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m0_req,
    input  logic            m0_wr,
    input  logic            m0_lock,
    input  logic [ADDR-1:0] m0_addr,
    input  logic [DATA-1:0] m0_din,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DATA-1:0] m0_rdata,
    input  logic            m1_req,
    input  logic            m1_wr,
    input  logic            m1_lock,
    input  logic [ADDR-1:0] m1_addr,
    input  logic [DATA-1:0] m1_din,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DATA-1:0] m1_rdata,
    output logic            ram_wr,
    output logic [ADDR-1:0] ram_addr,
    output logic [DATA-1:0] ram_din,
    input  logic [DATA-1:0] ram_dout
);

    logic            ptr_q;       // 0: requester 0 wins next contention
    logic            lock_vld_q;
    logic            lock_id_q;
    logic [1:0]      rvalid_q;    // bit 0: m0, bit 1: m1
    logic [ADDR-1:0] addr_q;
    logic [DATA-1:0] din_q;

    logic            gnt0_c;
    logic            gnt1_c;
    logic            gnt_any_c;
    logic            sel_wr_c;
    logic            sel_lock_c;
    logic [ADDR-1:0] sel_addr_c;
    logic [DATA-1:0] sel_din_c;

    // Grant decision: a held lock excludes the other requester entirely
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (lock_vld_q) begin
            if (lock_id_q) gnt1_c = m1_req;
            else           gnt0_c = m0_req;
        end else if (m0_req && m1_req) begin
            gnt0_c = ~ptr_q;
            gnt1_c = ptr_q;
        end else begin
            gnt0_c = m0_req;
            gnt1_c = m1_req;
        end
        // No grants may leak out while reset is asserted
        if (!rst_n) begin
            gnt0_c = 1'b0;
            gnt1_c = 1'b0;
        end
    end

    // Route the granted requester's command; hold last values when idle
    always_comb begin
        gnt_any_c  = gnt0_c | gnt1_c;
        sel_wr_c   = 1'b0;
        sel_lock_c = 1'b0;
        sel_addr_c = addr_q;
        sel_din_c  = din_q;
        if (gnt1_c) begin
            sel_wr_c   = m1_wr;
            sel_lock_c = m1_lock;
            sel_addr_c = m1_addr;
            sel_din_c  = m1_din;
        end else if (gnt0_c) begin
            sel_wr_c   = m0_wr;
            sel_lock_c = m0_lock;
            sel_addr_c = m0_addr;
            sel_din_c  = m0_din;
        end
    end

    // Pointer, lock, read-return pipeline and held RAM command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= 1'b0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
            rvalid_q   <= 2'b00;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            // Lock survives only while the owner keeps being granted with lock=1
            lock_vld_q <= gnt_any_c & sel_lock_c;
            rvalid_q   <= {gnt1_c & ~m1_wr, gnt0_c & ~m0_wr};
            if (gnt_any_c) begin
                ptr_q     <= gnt0_c;
                lock_id_q <= gnt1_c;
                addr_q    <= sel_addr_c;
                din_q     <= sel_din_c;
            end
        end
    end

    assign m0_gnt    = gnt0_c;
    assign m1_gnt    = gnt1_c;
    assign ram_wr    = gnt_any_c & sel_wr_c;
    assign ram_addr  = sel_addr_c;
    assign ram_din   = sel_din_c;
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = ram_dout;
    assign m1_rdata  = ram_dout;

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameters: DATA, default 16, word width; ADDR, default 13, word address width (8192-word screen memory).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 m0_req  input  1  requester 0 access request.
REQ-005 m0_wr  input  1  requester 0 write (1) / read (0).
REQ-006 m0_lock  input  1  requester 0 asks to keep the grant on the next cycle.
REQ-007 m0_addr  input  ADDR  requester 0 word address.
REQ-008 m0_din  input  DATA  requester 0 write data.
REQ-009 m0_gnt  output  1  requester 0 access accepted this cycle.
REQ-010 m0_rvalid  output  1  requester 0 read data valid.
REQ-011 m0_rdata  output  DATA  requester 0 read data.
REQ-012 m1_req, m1_wr, m1_lock, m1_addr, m1_din, m1_gnt, m1_rvalid, m1_rdata: same directions, widths and meanings, for requester 1.
REQ-013 ram_wr  output  1  write strobe to one RAM port.
REQ-014 ram_addr  output  ADDR  RAM port address.
REQ-015 ram_din  output  DATA  RAM port write data.
REQ-016 ram_dout  input  DATA  RAM port registered read data, valid one cycle after the address is sampled.

Function
REQ-017 Arbitration SHALL be per cycle and combinational from req inputs, the priority pointer and the lock state; at most one gnt SHALL be high in any cycle.
REQ-018 With exactly one req high and no lock held by the other requester, that requester SHALL be granted in the same cycle.
REQ-019 With both req high and no lock held, the requester named by the priority pointer SHALL be granted.
REQ-020 On every granted cycle the pointer SHALL move to the non-granted requester (round-robin); with no grant the pointer SHALL hold.
REQ-021 Lock state: if the granted requester has lock=1 in its grant cycle, lock_owner SHALL register that requester; in the next cycle only the owner may be granted, whatever the pointer.
REQ-022 Lock release: lock_owner SHALL clear at the end of any cycle in which the owner has req=0 or lock=0.
REQ-023 While a lock is held and the owner has req=0, no gnt SHALL be issued that cycle, even if the other requester is waiting.
REQ-024 While a lock is held, the pointer SHALL still update per REQ-020, so the other requester wins the first contended cycle after release.
REQ-025 In a grant cycle, ram_addr, ram_din and ram_wr SHALL equal the granted requester's addr, din and wr.
REQ-026 With no grant, ram_wr SHALL be 0 and ram_addr/ram_din SHALL hold their last granted values; no RAM write may occur.
REQ-027 Handshake: a requester SHALL hold req, wr, addr, din and lock stable until gnt; the transfer completes on the rising edge that ends the gnt cycle.
REQ-028 Read latency: for a granted read, mX_rvalid SHALL be 1 for exactly one cycle, the cycle after gnt, with mX_rdata = ram_dout.
REQ-029 Granted writes SHALL produce no rvalid; write completion is gnt.
REQ-030 Back-to-back: a requester granted on consecutive cycles SHALL receive rvalid on consecutive cycles, in order.
REQ-031 Read after write to the same address in the next cycle SHALL return the new data, since the RAM port forwards the written word.
REQ-032 mX_rdata SHALL equal ram_dout at all times; it is defined only while mX_rvalid=1.
REQ-033 Registered state: pointer (1 bit), lock_owner (valid bit and id), rvalid pipeline (2 bits) and the held RAM address/data registers.

Reset
REQ-034 While rst_n=0, asynchronously: pointer=requester 0, lock cleared, m0_rvalid=m1_rvalid=0, ram_addr=0, ram_din=0.
REQ-035 While rst_n=0, m0_gnt=m1_gnt=0 and ram_wr=0, regardless of req.
REQ-036 Reset asserted mid-transaction SHALL discard any pending rvalid; no rvalid SHALL appear after rst_n returns high.
REQ-037 Normal arbitration SHALL resume on the first rising edge after rst_n deasserts.

Verification
REQ-038 After reset, m0 reads addr 0x0005 (RAM holds 0x1234) -> m0_gnt same cycle; next cycle m0_rvalid=1, m0_rdata=0x1234.
REQ-039 Both requesters request every cycle for 4 cycles -> grants m0,m1,m0,m1; each rvalid follows its grant by one cycle.
REQ-040 m1 writes 0xBEEF to 0x1FFF with lock=1, then reads 0x1FFF with lock=0, while m0 requests throughout -> m1 granted 2 cycles, read returns 0xBEEF, m0 granted on the third cycle.
REQ-041 m1 holds lock then drops req while m0 waits -> no grant that cycle; m0 granted the following cycle.
REQ-042 rst_n pulled low in the cycle after an m0 read grant -> m0_rvalid stays 0; pointer=0, gnt=0 and ram_wr=0 during reset.
REQ-043 No requests for 10 cycles -> ram_wr=0 and ram_addr unchanged; a write during idle never reaches RAM (checked by reading the addresses back).
